// File: rtl/btn_pkg.sv
// Shared definitions for the button event arbiter: channel state encoding
// and the default debounce / long-press timing constants.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_HELD   = 2'd2,
        ST_DISARM = 2'd3
    } chan_state_t;

    localparam int DEF_DEB_CYCLES  = 16;
    localparam int DEF_LONG_CYCLES = 64;

endpackage

// File: rtl/btn_channel.sv
// One button lane: 2-FF synchronizer, debounce FSM with shared counter,
// and single-cycle press / long-press strobes toward the top-level flags.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_long
);

    localparam int CW = $clog2(LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    chan_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_long_done;
    logic          w_s;

    assign w_s     = r_sync2;
    assign o_level = r_level;

    // Strobes fire on the same edge the FSM commits the transition.
    assign o_press = (r_state == ST_ARM)  && w_s && (r_cnt == DEB_LAST);
    assign o_long  = (r_state == ST_HELD) && w_s && (r_cnt == LONG_LAST) && !r_long_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_long_done <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        r_state <= ST_ARM;
                        r_cnt   <= '0;
                    end
                end
                ST_ARM: begin
                    if (!w_s) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state     <= ST_HELD;
                        r_level     <= 1'b1;
                        r_cnt       <= '0;
                        r_long_done <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!w_s) begin
                        r_state <= ST_DISARM;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_long_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DISARM: begin
                    // A bounce back high resumes the hold without a new press.
                    if (w_s) begin
                        r_state     <= ST_HELD;
                        r_cnt       <= '0;
                        r_long_done <= 1'b0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced multi-button front end: per-button channels feed pending flags
// that a round-robin scheduler drains onto one valid/ready event port.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         button,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    output logic                     evt_drop,
    output logic [N_BTN-1:0]         btn_level
);

    localparam int IW = $clog2(N_BTN);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_long;
    logic [N_BTN-1:0] r_press_pend;
    logic [N_BTN-1:0] r_long_pend;
    logic [N_BTN-1:0] w_any;
    logic [N_BTN-1:0] w_clr_press;
    logic [N_BTN-1:0] w_clr_long;
    logic [IW-1:0]    r_rr;
    logic [IW-1:0]    w_gid;
    logic             w_found;
    logic             w_free;
    logic             w_gnt_long;
    logic             w_drop_hit;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (button[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g]),
            .o_long (w_long[g])
        );
    end

    assign btn_level = w_level;
    assign w_any     = r_press_pend | r_long_pend;
    assign w_free    = !evt_valid || evt_ready;

    always_comb begin : p_search
        logic [IW-1:0] idx;
        w_found = 1'b0;
        w_gid   = '0;
        idx     = '0;
        for (int off = 1; off <= N_BTN; off++) begin
            idx = IW'((int'(r_rr) + off) % N_BTN);
            if (!w_found && w_any[idx]) begin
                w_found = 1'b1;
                w_gid   = idx;
            end
        end
    end

    // Press is always served before long within the granted button.
    always_comb begin
        w_gnt_long  = !r_press_pend[w_gid];
        w_clr_press = '0;
        w_clr_long  = '0;
        if (w_free && w_found) begin
            if (w_gnt_long) w_clr_long[w_gid]  = 1'b1;
            else            w_clr_press[w_gid] = 1'b1;
        end
    end

    assign w_drop_hit = |(w_press & r_press_pend & ~w_clr_press)
                      | |(w_long  & r_long_pend  & ~w_clr_long);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_press_pend <= '0;
            r_long_pend  <= '0;
            r_rr         <= IW'(N_BTN - 1);
            evt_valid    <= 1'b0;
            evt_id       <= '0;
            evt_long     <= 1'b0;
            evt_drop     <= 1'b0;
        end else begin
            r_press_pend <= (r_press_pend & ~w_clr_press) | w_press;
            r_long_pend  <= (r_long_pend  & ~w_clr_long)  | w_long;
            if (w_drop_hit) evt_drop <= 1'b1;
            if (w_free) begin
                if (w_found) begin
                    evt_valid <= 1'b1;
                    evt_id    <= w_gid;
                    evt_long  <= w_gnt_long;
                    r_rr      <= w_gid;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule
